// File: rtl/display_refresh_ctrl.sv
// TM1638 refresh sequencer: streams MODE, 8 x (ADDR, DATA) and CTRL bytes built from latched BCD digits.
// Latency: a trigger is accepted in IDLE and the MODE byte is valid the next cycle; each digit costs >= 4 cycles.
// Backpressure: tx_valid/tx_ready handshake; bytes are held stable indefinitely while tx_ready is low.
module display_refresh_ctrl #(
    parameter int unsigned REFRESH_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] disp_data,
    input  logic [2:0]  bright,
    output logic [3:0]  bcd_out,
    input  logic [7:0]  seg_in,
    output logic [7:0]  tx_byte,
    output logic        tx_last,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [23:0] CNT_LAST  = 24'(REFRESH_CYC - 1);
    localparam logic [7:0]  MODE_BYTE = 8'h44;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MODE = 3'd1,
        S_BCD  = 3'd2,
        S_WAIT = 3'd3,
        S_ADDR = 3'd4,
        S_DATA = 3'd5,
        S_CTRL = 3'd6,
        S_FIN  = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [31:0] snap_data_q, snap_data_d;
    logic [2:0]  snap_bright_q, snap_bright_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  seg_q, seg_d;
    logic [3:0]  bcd_q, bcd_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_last_q, tx_last_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        refresh_hit;
    logic        trigger;
    logic        launch;
    logic        xfer;

    // A refresh fires on the last count of the free-running period; a pending
    // request left over from the previous sequence launches from IDLE as well.
    assign refresh_hit = (cnt_q == CNT_LAST);
    assign trigger     = start | refresh_hit;
    assign launch      = (state_q == S_IDLE) && (trigger || pend_q);
    assign xfer        = tx_valid_q && tx_ready;

    assign bcd_out  = bcd_q;
    assign tx_byte  = tx_byte_q;
    assign tx_last  = tx_last_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // State register and all datapath/output flops, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pend_q        <= 1'b0;
            snap_data_q   <= '0;
            snap_bright_q <= '0;
            idx_q         <= '0;
            seg_q         <= '0;
            bcd_q         <= '0;
            tx_byte_q     <= '0;
            tx_last_q     <= 1'b0;
            tx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            snap_data_q   <= snap_data_d;
            snap_bright_q <= snap_bright_d;
            idx_q         <= idx_d;
            seg_q         <= seg_d;
            bcd_q         <= bcd_d;
            tx_byte_q     <= tx_byte_d;
            tx_last_q     <= tx_last_d;
            tx_valid_q    <= tx_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Next-state sequencing; byte states only advance on an accepted transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (launch) state_d = S_MODE;
            S_MODE: if (xfer) state_d = S_BCD;
            S_BCD:  state_d = S_WAIT;
            S_WAIT: state_d = S_ADDR;
            S_ADDR: if (xfer) state_d = S_DATA;
            S_DATA: begin
                if (xfer) begin
                    state_d = (idx_q == 3'd7) ? S_CTRL : S_BCD;
                end
            end
            S_CTRL: if (xfer) state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Refresh counter, pending merge, input snapshots, digit index and segment capture.
    always_comb begin
        cnt_d         = refresh_hit ? 24'd0 : cnt_q + 24'd1;
        pend_d        = pend_q;
        snap_data_d   = snap_data_q;
        snap_bright_d = snap_bright_q;
        idx_d         = idx_q;
        seg_d         = seg_q;

        // Any number of triggers during a sequence collapse into one rerun.
        if (state_q != S_IDLE) begin
            if (trigger) pend_d = 1'b1;
        end else if (launch) begin
            pend_d = 1'b0;
        end

        if (launch) begin
            snap_data_d   = disp_data;
            snap_bright_d = bright;
            idx_d         = 3'd0;
        end

        if ((state_q == S_DATA) && xfer && (idx_q != 3'd7)) begin
            idx_d = idx_q + 3'd1;
        end

        // The decoder answers one cycle after sampling bcd_out, i.e. during WAIT.
        if (state_q == S_WAIT) begin
            seg_d = seg_in;
        end
    end

    // Registered outputs derived from the state being entered, so they align with state_q.
    always_comb begin
        tx_valid_d = 1'b0;
        tx_byte_d  = 8'h00;
        tx_last_d  = 1'b0;
        bcd_d      = bcd_q;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FIN);
        case (state_d)
            S_MODE: begin
                tx_valid_d = 1'b1;
                tx_byte_d  = MODE_BYTE;
                tx_last_d  = 1'b1;
            end
            S_BCD: begin
                bcd_d = snap_data_q[{idx_d, 2'b00} +: 4];
            end
            S_ADDR: begin
                tx_valid_d = 1'b1;
                tx_byte_d  = {4'hC, idx_d, 1'b0};
                tx_last_d  = 1'b0;
            end
            S_DATA: begin
                tx_valid_d = 1'b1;
                tx_byte_d  = seg_q;
                tx_last_d  = 1'b1;
            end
            S_CTRL: begin
                tx_valid_d = 1'b1;
                tx_byte_d  = {5'b10001, snap_bright_q};
                tx_last_d  = 1'b1;
            end
            default: begin
                tx_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_display_refresh_ctrl.sv
// Bench for display_refresh_ctrl: table vectors, random data/backpressure against a frame-level model.
// A registered BCD decoder model closes the bcd_out -> seg_in loop.
// A second instance with a 100-cycle refresh period exercises automatic triggering.
module tb_display_refresh_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default refresh period, never reached in this run)
    logic        rst;
    logic        start;
    logic [31:0] disp_data;
    logic [2:0]  bright;
    logic [3:0]  bcd_out;
    logic [7:0]  seg_in;
    logic [7:0]  tx_byte;
    logic        tx_last;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;

    // Auto-refresh instance
    logic        rst_r;
    logic        start_r;
    logic [3:0]  bcd_r;
    logic [7:0]  seg_r;
    logic [7:0]  txb_r;
    logic        txl_r;
    logic        txv_r;
    logic        ready_r;
    logic        busy_r;
    logic        done_r;

    assign start_r = 1'b0;
    assign ready_r = 1'b1;

    display_refresh_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .disp_data(disp_data), .bright(bright),
        .bcd_out(bcd_out), .seg_in(seg_in), .tx_byte(tx_byte), .tx_last(tx_last),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    display_refresh_ctrl #(.REFRESH_CYC(100)) dut_r (
        .clk(clk), .rst(rst_r), .start(start_r), .disp_data(disp_data), .bright(bright),
        .bcd_out(bcd_r), .seg_in(seg_r), .tx_byte(txb_r), .tx_last(txl_r),
        .tx_valid(txv_r), .tx_ready(ready_r), .busy(busy_r), .done(done_r)
    );

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 8'h3F;
            4'd1: return 8'h06;
            4'd2: return 8'h5B;
            4'd3: return 8'h4F;
            4'd4: return 8'h66;
            4'd5: return 8'h6D;
            4'd6: return 8'h7D;
            4'd7: return 8'h07;
            4'd8: return 8'h7F;
            4'd9: return 8'h6F;
            default: return 8'h3F;
        endcase
    endfunction

    // Registered decoders feeding each instance
    always @(posedge clk) begin
        seg_in <= seg7(bcd_out);
        seg_r  <= seg7(bcd_r);
    end

    // Backpressure driver
    bit rnd_ready = 1'b0;
    always @(posedge clk) begin
        #2;
        tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main-instance monitor: transfers, digit codes, done pulses, hold stability
    logic [7:0] byte_q[$];
    bit         last_q[$];
    logic [3:0] bcd_q[$];
    int         done_cnt = 0;
    bit         armed = 1'b0;
    int         gap = 0;
    int         restart_gap = -1;
    bit         wait_prev = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic       prev_last = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            wait_prev = 1'b0;
        end else begin
            if (wait_prev) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_byte", 32'(tx_byte), 32'(prev_byte));
                chk("hold_last", 32'(tx_last), 32'(prev_last));
            end
            if (tx_valid && tx_ready) begin
                byte_q.push_back(tx_byte);
                last_q.push_back(tx_last);
                if (!tx_last) bcd_q.push_back(bcd_out);
            end
            wait_prev = tx_valid && !tx_ready;
            prev_byte = tx_byte;
            prev_last = tx_last;
            if (done) begin
                done_cnt++;
                armed = 1'b1;
                gap = 0;
            end else if (armed) begin
                gap++;
                if (tx_valid) begin
                    armed = 1'b0;
                    restart_gap = gap;
                end
            end
        end
    end

    // Auto-refresh instance monitor
    int         nbytes_r = 0;
    int         nlast_r = 0;
    logic [7:0] first_r = 8'h00;
    int         done_cyc_r[$];

    always @(negedge clk) begin
        if (rst_r) begin
            if (txv_r && ready_r) begin
                if (nbytes_r == 0) first_r = txb_r;
                nbytes_r++;
                if (txl_r) nlast_r++;
            end
            if (done_r) done_cyc_r.push_back(cyc);
        end
    end

    // Frame-level reference: MODE, then address/segment pairs per digit, then CTRL
    logic [7:0] exp_b[$];
    bit         exp_l[$];
    logic [3:0] exp_bcd[$];

    task automatic build_exp(input logic [31:0] d, input logic [2:0] b);
        exp_b.delete(); exp_l.delete(); exp_bcd.delete();
        exp_b.push_back(8'h44); exp_l.push_back(1'b1);
        for (int i = 0; i < 8; i++) begin
            exp_b.push_back(8'hC0 + 8'(2 * i)); exp_l.push_back(1'b0);
            exp_b.push_back(seg7(d[4*i +: 4]));  exp_l.push_back(1'b1);
            exp_bcd.push_back(d[4*i +: 4]);
        end
        exp_b.push_back(8'h88 | {5'b0, b}); exp_l.push_back(1'b1);
    endtask

    task automatic cmp_stream(input string tag, input int off);
        logic [7:0] ab;
        logic       al;
        logic [3:0] ad;
        int         boff;
        boff = (off / 18) * 8;
        for (int i = 0; i < exp_b.size(); i++) begin
            ab = (off + i < byte_q.size()) ? byte_q[off + i] : 8'hxx;
            al = (off + i < last_q.size()) ? last_q[off + i] : 1'bx;
            chk($sformatf("%s_byte%0d", tag, i), 32'(ab), 32'(exp_b[i]));
            chk($sformatf("%s_last%0d", tag, i), 32'(al), 32'(exp_l[i]));
        end
        for (int i = 0; i < exp_bcd.size(); i++) begin
            ad = (boff + i < bcd_q.size()) ? bcd_q[boff + i] : 4'hx;
            chk($sformatf("%s_bcd%0d", tag, i), 32'(ad), 32'(exp_bcd[i]));
        end
    endtask

    task automatic clr();
        byte_q.delete(); last_q.delete(); bcd_q.delete();
        done_cnt = 0;
        armed = 1'b0;
        restart_gap = -1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #2; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int t = 0;
        while (done_cnt < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt), 32'(n));
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int t = 0;
        while (byte_q.size() < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        chk({tag, "_bytes_seen"}, 32'(byte_q.size() >= n), 32'd1);
    endtask

    // One full sequence; inputs are scrambled right after the snapshot edge.
    task automatic run_one(input logic [31:0] d, input logic [2:0] b, input bit rnd, input string tag);
        clr();
        rnd_ready = rnd;
        @(posedge clk); #2;
        disp_data = d;
        bright    = b;
        start     = 1'b1;
        @(posedge clk); #2;
        start     = 1'b0;
        disp_data = $urandom;
        bright    = 3'($urandom_range(0, 7));
        wait_done(1, 800, tag);
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_nbytes"}, 32'(byte_q.size()), 32'd18);
        build_exp(d, b);
        cmp_stream(tag, 0);
    endtask

    typedef struct {
        logic [31:0] data;
        logic [2:0]  bright;
        bit          rnd;
        logic [7:0]  exp_ctrl;
        logic [7:0]  exp_seg0;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{32'h87654321, 3'd5, 1'b0, 8'h8D, 8'h06};
        vecs[1] = '{32'h87654321, 3'd5, 1'b1, 8'h8D, 8'h06};
        vecs[2] = '{32'hFFFFFFFA, 3'd0, 1'b0, 8'h88, 8'h3F};
        vecs[3] = '{32'h09090909, 3'd7, 1'b1, 8'h8F, 8'h6F};

        rst = 1'b0; rst_r = 1'b0; start = 1'b0;
        disp_data = 32'h0; bright = 3'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'h00);
        chk("rst_tx_last", 32'(tx_last), 32'd0);
        chk("rst_bcd_out", 32'(bcd_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #2; rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_valid", 32'(tx_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Table vectors
        for (int v = 0; v < 4; v++) begin
            run_one(vecs[v].data, vecs[v].bright, vecs[v].rnd, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_ctrl", v), 32'(byte_q.size() > 17 ? byte_q[17] : 8'hxx), 32'(vecs[v].exp_ctrl));
            chk($sformatf("vec%0d_seg0", v), 32'(byte_q.size() > 2 ? byte_q[2] : 8'hxx), 32'(vecs[v].exp_seg0));
        end

        // Random data and backpressure
        for (int r = 0; r < 4; r++) begin
            logic [31:0] d;
            logic [2:0]  b;
            d = $urandom;
            b = 3'($urandom_range(0, 7));
            run_one(d, b, 1'b1, $sformatf("rnd%0d", r));
        end

        // Two triggers mid-sequence merge into exactly one rerun
        clr();
        rnd_ready = 1'b0;
        @(posedge clk); #2;
        disp_data = 32'h87654321; bright = 3'd5;
        pulse_start();
        wait_bytes(5, 200, "merge");
        #2;
        disp_data = 32'h13579BDF; bright = 3'd2;
        pulse_start();
        repeat (3) @(posedge clk);
        pulse_start();
        wait_done(2, 400, "merge");
        repeat (60) @(posedge clk);
        #1;
        chk("merge_done_pulses", 32'(done_cnt), 32'd2);
        chk("merge_restart_gap", 32'(restart_gap), 32'd2);
        chk("merge_nbytes", 32'(byte_q.size()), 32'd36);
        build_exp(32'h87654321, 3'd5);
        cmp_stream("merge_a", 0);
        build_exp(32'h13579BDF, 3'd2);
        cmp_stream("merge_b", 18);

        // Reset during the 7th byte aborts the frame
        clr();
        @(posedge clk); #2;
        disp_data = 32'h11223344; bright = 3'd1;
        pulse_start();
        wait_bytes(6, 200, "abort");
        #3;
        chk("abort_pre_valid", 32'(tx_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_valid_low", 32'(tx_valid), 32'd0);
        chk("abort_busy_low", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #2; rst = 1'b1;
        clr();
        repeat (60) @(posedge clk);
        #1;
        chk("abort_no_bytes", 32'(byte_q.size()), 32'd0);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        run_one(32'h24680135, 3'd6, 1'b0, "recover");

        // Automatic refresh every 100 cycles
        @(posedge clk); #2; rst_r = 1'b1;
        repeat (360) @(posedge clk);
        #1;
        chk("auto_done_count", 32'(done_cyc_r.size()), 32'd3);
        if (done_cyc_r.size() >= 3) begin
            chk("auto_period_1", 32'(done_cyc_r[1] - done_cyc_r[0]), 32'd100);
            chk("auto_period_2", 32'(done_cyc_r[2] - done_cyc_r[1]), 32'd100);
        end
        chk("auto_nbytes", 32'(nbytes_r), 32'd54);
        chk("auto_nlast", 32'(nlast_r), 32'd30);
        chk("auto_first_byte", 32'(first_r), 32'h44);
        chk("auto_busy_idle", 32'(busy_r), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/display_refresh_ctrl.md
DISPLAY_REFRESH_CTRL -- requirements
Module: display_refresh_ctrl

Interface
REQ-001 Parameter REFRESH_CYC, default 50000: clk cycles between automatic refresh triggers; legal range 32..2^24-1.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle refresh request.
REQ-005 disp_data  input  32  eight packed BCD digits; digit i = disp_data[4i+3:4i], digit 0 at TM1638 address 0xC0.
REQ-006 bright  input  3  display brightness, 0..7.
REQ-007 bcd_out  output  4  digit code driven to the registered BCD-to-segment decoder.
REQ-008 seg_in  input  8  segment byte returned by the decoder, one clock after it samples bcd_out.
REQ-009 tx_byte  output  8  byte to the TM1638 serial transmitter.
REQ-010 tx_last  output  1  marks the final byte of a STB frame.
REQ-011 tx_valid  output  1  tx_byte/tx_last are valid.
REQ-012 tx_ready  input  1  transmitter accepts a byte.
REQ-013 busy  output  1  high from sequence start until done.
REQ-014 done  output  1  one-cycle pulse at sequence end.

Function
REQ-015 Byte transfer SHALL occur on a rising edge with tx_valid=1 and tx_ready=1; tx_byte and tx_last SHALL stay stable while tx_valid=1 and no transfer has occurred.
REQ-016 States: IDLE, MODE, BCD, WAIT, ADDR, DATA, CTRL, FIN.
REQ-017 A trigger is start=1, or the refresh counter reaching REFRESH_CYC-1; the counter SHALL run continuously from 0, wrap to 0 on expiry, and never pause.
REQ-018 IDLE + trigger: disp_data and bright SHALL be latched into internal snapshots, digit index cleared to 0, busy set, next state MODE.
REQ-019 MODE: send 0x44 with tx_last=1 (fixed-address write); on transfer go to BCD.
REQ-020 BCD: bcd_out = snapshot digit[index], registered, held until next BCD; one cycle, go to WAIT.
REQ-021 WAIT: one cycle; at its exit edge capture seg_in into a segment register; go to ADDR.
REQ-022 ADDR: send 0xC0 + 2*index with tx_last=0; on transfer go to DATA.
REQ-023 DATA: send the captured segment byte with tx_last=1; on transfer, if index=7 go to CTRL, else increment index and go to BCD.
REQ-024 CTRL: send 0x88 | bright_snapshot with tx_last=1; on transfer go to FIN.
REQ-025 FIN: pulse done for one cycle, clear busy, return to IDLE.
REQ-026 Each sequence SHALL transfer exactly 18 bytes in the order: MODE, 8 x (ADDR, DATA), CTRL.
REQ-027 tx_valid SHALL be 1 only in MODE, ADDR, DATA and CTRL.
REQ-028 Digit codes 10..15 SHALL be passed to bcd_out unmodified; the returned seg_in SHALL be sent as-is.
REQ-029 A trigger while busy SHALL set a single pending flag; further triggers while pending SHALL be merged into it.
REQ-030 FIN with the pending flag set SHALL clear the flag and start a new sequence on the next cycle, from IDLE with fresh snapshots.
REQ-031 disp_data and bright changes during a sequence SHALL NOT affect that sequence.
REQ-032 With tx_ready held low, the block SHALL wait indefinitely with outputs stable; there is no timeout.

Reset
REQ-033 While rst=0, all registers SHALL clear immediately: state IDLE, tx_valid=0, tx_byte=0x00, tx_last=0, bcd_out=0, busy=0, done=0, index=0, pending=0, refresh counter=0.
REQ-034 Reset mid-sequence SHALL abort without completing the frame; after release the block SHALL wait for the next trigger.

Verification
REQ-035 disp_data=0x87654321, bright=5, start pulse, tx_ready=1: bytes 44,C0,06,C2,5B,C4,4F,C6,66,C8,6D,CA,7D,CC,07,CE,7F,8D; tx_last on bytes 1,3,5,...,17,18; one done pulse.
REQ-036 Same as REQ-035 with tx_ready toggling randomly: identical byte stream; tx_byte stable while waiting for acceptance.
REQ-037 start pulsed twice during a sequence: exactly one extra sequence, starting the cycle after done.
REQ-038 disp_data=0xFFFFFFFA: bcd_out shows A,F,... and the decoder default bytes 0x3F are sent.
REQ-039 REFRESH_CYC=100, no start: triggers every 100 cycles; with tx_ready=1 each sequence completes before the next trigger.
REQ-040 rst asserted at the 7th byte: tx_valid and busy low within the same cycle; after release, no bytes until a trigger.
